// File: rtl/pipe_hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves load-use, taken-branch
// and data-memory-wait hazards with same-cycle control outputs.
module pipe_hazard_sequencer #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_WAIT     = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_idex_memread,
    input  logic [4:0]       i_idex_rt,
    input  logic             i_branch_taken,
    input  logic             i_mem_busy,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_ifid_flush,
    output logic             o_idex_write,
    output logic             o_idex_bubble,
    output logic             o_exmem_write,
    output logic             o_exmem_flush,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic             o_wait_timeout
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    state_t           r_state;
    logic [2:0]       r_flush_cnt;
    logic [7:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic             r_wait_timeout;

    state_t     w_next_state;
    logic [2:0] w_next_flush_cnt;
    logic [7:0] w_next_wait_cnt;
    logic       w_set_timeout;
    logic       w_lu;
    logic       w_pc_write;
    logic       w_ifid_write;
    logic       w_ifid_flush;
    logic       w_idex_write;
    logic       w_idex_bubble;
    logic       w_exmem_write;
    logic       w_exmem_flush;

    assign w_lu = i_idex_memread && (i_idex_rt != 5'd0) &&
                  ((i_idex_rt == i_id_rs) || (i_id_uses_rt && (i_idex_rt == i_id_rt)));

    always_comb begin
        w_next_state     = r_state;
        w_next_flush_cnt = r_flush_cnt;
        w_next_wait_cnt  = r_wait_cnt;
        w_set_timeout    = 1'b0;
        w_pc_write       = 1'b0;
        w_ifid_write     = 1'b0;
        w_ifid_flush     = 1'b0;
        w_idex_write     = 1'b0;
        w_idex_bubble    = 1'b0;
        w_exmem_write    = 1'b0;
        w_exmem_flush    = 1'b0;
        if (!rst) begin
            if (i_mem_busy) begin
                // Whole pipe frozen; FLUSH simply holds its remaining count.
                if (r_state == MEM_WAIT) begin
                    if (r_wait_cnt < 8'(MAX_WAIT))
                        w_next_wait_cnt = r_wait_cnt + 8'd1;
                    if (r_wait_cnt >= 8'(MAX_WAIT - 1))
                        w_set_timeout = 1'b1;
                end else if (r_state != FLUSH) begin
                    w_next_state    = MEM_WAIT;
                    w_next_wait_cnt = 8'd1;
                end
            end else if (r_state == FLUSH) begin
                w_pc_write       = 1'b1;
                w_ifid_write     = 1'b1;
                w_idex_write     = 1'b1;
                w_exmem_write    = 1'b1;
                w_ifid_flush     = 1'b1;
                w_idex_bubble    = 1'b1;
                w_next_flush_cnt = r_flush_cnt - 3'd1;
                if (r_flush_cnt <= 3'd1)
                    w_next_state = RUN;
            end else begin
                // RUN, or MEM_WAIT whose memory just became ready, behaves as RUN.
                w_pc_write      = 1'b1;
                w_ifid_write    = 1'b1;
                w_idex_write    = 1'b1;
                w_exmem_write   = 1'b1;
                w_next_state    = RUN;
                w_next_wait_cnt = 8'd0;
                if (i_branch_taken) begin
                    w_ifid_flush  = 1'b1;
                    w_idex_bubble = 1'b1;
                    w_exmem_flush = 1'b1;
                    if (FLUSH_CYCLES > 0) begin
                        w_next_state     = FLUSH;
                        w_next_flush_cnt = 3'(FLUSH_CYCLES);
                    end
                end else if (w_lu) begin
                    w_pc_write    = 1'b0;
                    w_ifid_write  = 1'b0;
                    w_idex_bubble = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RUN;
            r_flush_cnt    <= 3'd0;
            r_wait_cnt     <= 8'd0;
            r_stall_cycles <= '0;
            r_wait_timeout <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_flush_cnt <= w_next_flush_cnt;
            r_wait_cnt  <= w_next_wait_cnt;
            if (w_set_timeout)
                r_wait_timeout <= 1'b1;
            if (!w_pc_write && (r_stall_cycles != {CNT_W{1'b1}}))
                r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    // A flush or bubble only has meaning on a register that is actually loading.
    assign o_pc_write     = w_pc_write;
    assign o_ifid_write   = w_ifid_write;
    assign o_ifid_flush   = w_ifid_flush & w_ifid_write;
    assign o_idex_write   = w_idex_write;
    assign o_idex_bubble  = w_idex_bubble & w_idex_write;
    assign o_exmem_write  = w_exmem_write;
    assign o_exmem_flush  = w_exmem_flush & w_exmem_write;
    assign o_state        = r_state;
    assign o_stall_cycles = r_stall_cycles;
    assign o_wait_timeout = r_wait_timeout;

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Directed, scoreboard-based bench for pipe_hazard_sequencer (default parameters).
module tb_pipe_hazard_sequencer;

    logic        clk;
    logic        rst;
    logic [4:0]  idRs;
    logic [4:0]  idRt;
    logic        idUsesRt;
    logic        idexMemread;
    logic [4:0]  idexRt;
    logic        branchTaken;
    logic        memBusy;
    logic        pcWrite;
    logic        ifidWrite;
    logic        ifidFlush;
    logic        idexWrite;
    logic        idexBubble;
    logic        exmemWrite;
    logic        exmemFlush;
    logic [1:0]  state;
    logic [15:0] stallCycles;
    logic        waitTimeout;

    typedef struct packed {
        logic [6:0]  ctrl;
        logic [1:0]  st;
        logic [15:0] stall;
        logic        tout;
    } exp_t;

    exp_t expQ[$];
    int   assertions = 0;
    int   failures   = 0;
    int   stepNum    = 0;

    // Control vector order: pc_w, ifid_w, ifid_flush, idex_w, idex_bubble, exmem_w, exmem_flush
    localparam logic [6:0] DEF = 7'b1101010;
    localparam logic [6:0] LU  = 7'b0001110;
    localparam logic [6:0] BR  = 7'b1111111;
    localparam logic [6:0] FL  = 7'b1111110;
    localparam logic [6:0] FRZ = 7'b0000000;
    localparam logic [1:0] S_RUN = 2'd0, S_MW = 2'd2, S_FL = 2'd3;

    pipe_hazard_sequencer #(.FLUSH_CYCLES(1), .MAX_WAIT(16), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_id_rs        (idRs),
        .i_id_rt        (idRt),
        .i_id_uses_rt   (idUsesRt),
        .i_idex_memread (idexMemread),
        .i_idex_rt      (idexRt),
        .i_branch_taken (branchTaken),
        .i_mem_busy     (memBusy),
        .o_pc_write     (pcWrite),
        .o_ifid_write   (ifidWrite),
        .o_ifid_flush   (ifidFlush),
        .o_idex_write   (idexWrite),
        .o_idex_bubble  (idexBubble),
        .o_exmem_write  (exmemWrite),
        .o_exmem_flush  (exmemFlush),
        .o_state        (state),
        .o_stall_cycles (stallCycles),
        .o_wait_timeout (waitTimeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput();
        exp_t e;
        logic [6:0] obs;
        if (expQ.size() == 0) begin
            assertions++;
            failures++;
            $error("[TB] FAIL step%0d queue: observed empty scoreboard, expected an entry", stepNum);
            return;
        end
        e   = expQ.pop_front();
        obs = {pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble, exmemWrite, exmemFlush};
        assertions++;
        assert (obs === e.ctrl) else begin
            failures++;
            $error("[TB] FAIL step%0d ctrl: observed %b expected %b", stepNum, obs, e.ctrl);
        end
        assertions++;
        assert (state === e.st) else begin
            failures++;
            $error("[TB] FAIL step%0d state: observed %0d expected %0d", stepNum, state, e.st);
        end
        assertions++;
        assert (stallCycles === e.stall) else begin
            failures++;
            $error("[TB] FAIL step%0d stall_cycles: observed %0d expected %0d", stepNum, stallCycles, e.stall);
        end
        assertions++;
        assert (waitTimeout === e.tout) else begin
            failures++;
            $error("[TB] FAIL step%0d wait_timeout: observed %b expected %b", stepNum, waitTimeout, e.tout);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic usesRt, input logic memread, input logic [4:0] xRt,
                                 input logic br, input logic busy, input logic [6:0] eCtrl,
                                 input logic [1:0] eSt, input logic [15:0] eStall, input logic eTout);
        exp_t e;
        @(negedge clk);
        stepNum++;
        rst         = r;
        idRs        = rs;
        idRt        = rt;
        idUsesRt    = usesRt;
        idexMemread = memread;
        idexRt      = xRt;
        branchTaken = br;
        memBusy     = busy;
        e.ctrl  = eCtrl;
        e.st    = eSt;
        e.stall = eStall;
        e.tout  = eTout;
        expQ.push_back(e);
        #2;
        checkOutput();
    endtask

    // The stimulus must never present a branch while the sequencer is flushing.
    always @(negedge clk) begin
        #3;
        if (!rst && state == S_FL) begin
            assert (branchTaken !== 1'b1) else begin
                failures++;
                $error("[TB] FAIL illegal_branch_in_flush: observed 1 expected 0");
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; idRs = '0; idRt = '0; idUsesRt = 1'b0; idexMemread = 1'b0;
        idexRt = '0; branchTaken = 1'b0; memBusy = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, FRZ, S_RUN, 16'd0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, DEF, S_RUN, 16'd0, 0);
        // Load-use on rs, then bubble removes memread
        applyStimulus(0, 8, 0, 0, 1, 8, 0, 0, LU,  S_RUN, 16'd0, 0);
        applyStimulus(0, 8, 0, 0, 0, 8, 0, 0, DEF, S_RUN, 16'd1, 0);
        // r0 destination and unused rt never stall
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, DEF, S_RUN, 16'd1, 0);
        applyStimulus(0, 3, 8, 0, 1, 8, 0, 0, DEF, S_RUN, 16'd1, 0);
        applyStimulus(0, 3, 8, 1, 1, 8, 0, 0, LU,  S_RUN, 16'd1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, DEF, S_RUN, 16'd2, 0);
        // Taken branch, then one FLUSH cycle that ignores a load-use pattern
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, BR,  S_RUN, 16'd2, 0);
        applyStimulus(0, 8, 0, 0, 1, 8, 0, 0, FL,  S_FL,  16'd2, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, DEF, S_RUN, 16'd2, 0);
        // mem_busy for 3 cycles outranks a pending branch
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, FRZ, S_RUN, 16'd2, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, FRZ, S_MW,  16'd3, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, FRZ, S_MW,  16'd4, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, BR,  S_MW,  16'd5, 0);
        // Busy during FLUSH freezes and holds the flush count
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, FRZ, S_FL,  16'd5, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, FL,  S_FL,  16'd6, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, DEF, S_RUN, 16'd6, 0);
        // 20 busy cycles: timeout visible from the 16th MEM_WAIT cycle and sticky
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, FRZ, S_RUN, 16'd6, 0);
        for (int k = 1; k <= 19; k++)
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, FRZ, S_MW, 16'(6 + k), (k >= 16));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, DEF, S_MW,  16'd26, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, DEF, S_RUN, 16'd26, 1);
        // Reset arriving mid-FLUSH
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, BR,  S_RUN, 16'd26, 1);
        applyStimulus(1, 8, 0, 0, 1, 8, 0, 0, FRZ, S_FL,  16'd26, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, FRZ, S_RUN, 16'd0,  0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, DEF, S_RUN, 16'd0,  0);
        applyStimulus(0, 5, 0, 0, 1, 5, 0, 0, LU,  S_RUN, 16'd0,  0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, DEF, S_RUN, 16'd1,  0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_sequencer.md
Name: pipe_hazard_sequencer

Overview:
- Central stall/flush controller for the 5-stage pipeline. Drives write-enable, flush and bubble controls for PC, IF/ID, ID/EX and EX/MEM.
- Sequences three hazard types: load-use stalls, taken-branch flushes, and data-memory wait freezes.
- Keeps a saturating stall-cycle counter and a sticky memory-wait timeout flag for debug.
- Sits beside the decode stage. Control outputs are Mealy (same-cycle) so hazards are resolved without added latency.

Parameters:
FLUSH_CYCLES  1   extra cycles after a taken branch during which wrong-path fetch is squashed (0..7)
MAX_WAIT      16  consecutive mem_busy cycles in MEM_WAIT after which wait_timeout sets (2..255)
CNT_W         16  width of stall_cycles

Ports:
clk            in   1      clock
rst            in   1      reset
id_rs          in   5      rs field of instruction in ID
id_rt          in   5      rt field of instruction in ID
id_uses_rt     in   1      ID instruction reads rt as a source
idex_memread   in   1      MemRead control currently held in ID/EX
idex_rt        in   5      destination rt held in ID/EX
branch_taken   in   1      taken branch resolved in EX/MEM
mem_busy       in   1      data memory not ready this cycle
pc_write       out  1      PC load enable
ifid_write     out  1      IF/ID load enable
ifid_flush     out  1      IF/ID loads zeros (NOP)
idex_write     out  1      ID/EX load enable
idex_bubble    out  1      ID/EX wb/mem/ex control fields load zeros
exmem_write    out  1      EX/MEM load enable
exmem_flush    out  1      EX/MEM control fields load zeros
state          out  2      RUN=0, MEM_WAIT=2, FLUSH=3 (1 unused)
stall_cycles   out  CNT_W  count of cycles with pc_write=0, saturating
wait_timeout   out  1      sticky memory-wait timeout

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk. Reset sets state=RUN, stall_cycles=0, wait_timeout=0, internal flush_cnt=0, wait_cnt=0.
- While rst=1, all combinational outputs are 0, including the write enables.
- Default outputs (no hazard): all *_write=1, all flush and bubble outputs=0.
- Load-use hazard: lu = idex_memread & (idex_rt!=0) & (idex_rt==id_rs | (id_uses_rt & idex_rt==id_rt)).
- Priority in RUN, highest first: mem_busy > branch_taken > lu.
- RUN + mem_busy:
  - pc_write, ifid_write, idex_write, exmem_write all 0; no flush.
  - Next state MEM_WAIT, wait_cnt<=1.
- RUN + branch_taken:
  - pc_write=1; ifid_flush=1; idex_bubble=1; exmem_flush=1.
  - If FLUSH_CYCLES>0, next state FLUSH with flush_cnt<=FLUSH_CYCLES; otherwise stay RUN.
- RUN + lu:
  - pc_write=0, ifid_write=0, idex_bubble=1; idex_write and exmem_write stay 1.
  - Stay RUN. The stall lasts one cycle and is self-clearing, because the bubble removes idex_memread.
- MEM_WAIT + mem_busy:
  - All writes stay 0.
  - wait_cnt increments, saturating at MAX_WAIT; when wait_cnt==MAX_WAIT, wait_timeout<=1.
  - wait_timeout stays 1 until rst.
- MEM_WAIT + !mem_busy: outputs and next state are exactly as in RUN with the same inputs (branch/lu are evaluated in that cycle); wait_cnt<=0.
- FLUSH + !mem_busy:
  - pc_write=1, ifid_flush=1, idex_bubble=1.
  - flush_cnt decrements; when flush_cnt==1, next state is RUN.
  - lu is ignored, because the ID instruction is being squashed.
- FLUSH + mem_busy: all writes 0, flush_cnt held, stay FLUSH.
- branch_taken while in FLUSH is illegal (EX/MEM has already been flushed). It is ignored, and the bench asserts it never occurs.
- stall_cycles increments every non-reset cycle with pc_write=0, saturating at 2^CNT_W-1.
- The flush/bubble outputs apply only when the corresponding *_write=1.

Test Plan:
- Load-use: idex_memread=1, idex_rt=8, id_rs=8 for one cycle, then the bubble drops memread -> exactly one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cycles=1.
- idex_rt=0 with memread=1 and id_rs=0 -> no stall. id_uses_rt=0, id_rt=8, idex_rt=8 -> no stall.
- Branch with FLUSH_CYCLES=1: branch_taken pulse -> cycle0 has ifid_flush, idex_bubble and exmem_flush all 1; cycle1 state=FLUSH with ifid_flush=1 and exmem_flush=0; cycle2 state=RUN.
- mem_busy held 3 cycles while branch_taken=1 -> 3 cycles of all writes=0 (state=MEM_WAIT); on the 4th cycle the branch flush is applied; stall_cycles=3.
- mem_busy held 20 cycles (MAX_WAIT=16) -> wait_timeout=1 from the 16th MEM_WAIT cycle; still 1 after mem_busy drops; cleared only by rst.
- rst asserted mid-FLUSH -> all outputs 0 during reset; afterwards state=RUN, counters 0, default outputs resume.
